// File: rtl/flag_pkg.sv
// Shared flag bit positions, condition-select encodings and the condition
// evaluator used by the flag status unit.
package flag_pkg;

    localparam int FLAG_COUNT = 5;

    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_ODD   = 1;
    localparam int FLAG_AUX   = 2;
    localparam int FLAG_EVEN  = 3;
    localparam int FLAG_CARRY = 4;

    typedef enum logic [2:0] {
        COND_ZERO     = 3'd0,
        COND_ODD      = 3'd1,
        COND_AUX      = 3'd2,
        COND_EVEN     = 3'd3,
        COND_CARRY    = 3'd4,
        COND_NZERO    = 3'd5,
        COND_NCARRY   = 3'd6,
        COND_ALWAYS   = 3'd7
    } cond_e;

    function automatic logic eval_cond(input logic [2:0] sel,
                                       input logic [FLAG_COUNT-1:0] flags);
        logic res;
        case (cond_e'(sel))
            COND_ZERO:   res = flags[FLAG_ZERO];
            COND_ODD:    res = flags[FLAG_ODD];
            COND_AUX:    res = flags[FLAG_AUX];
            COND_EVEN:   res = flags[FLAG_EVEN];
            COND_CARRY:  res = flags[FLAG_CARRY];
            COND_NZERO:  res = ~flags[FLAG_ZERO];
            COND_NCARRY: res = ~flags[FLAG_CARRY];
            COND_ALWAYS: res = 1'b1;
            default:     res = 1'b1;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/flag_fifo.sv
// Result FIFO holding {sum, flags} pairs; head is presented straight from
// storage, and a full FIFO refuses new entries without pass-through.
module flag_fifo #(
    parameter int DATA_W = 8,
    parameter int FLAG_W = 5,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_sum,
    input  logic [FLAG_W-1:0] in_flags,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_sum,
    output logic [FLAG_W-1:0] out_flags,
    input  logic              out_ready,
    output logic              push
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [DATA_W+FLAG_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]            wr_ptr_r;
    logic [AW-1:0]            rd_ptr_r;
    logic [AW:0]              count_r;
    logic                     pop_s;
    logic [DATA_W+FLAG_W-1:0] head_s;

    assign in_ready  = (count_r < FULL_CNT);
    assign out_valid = (count_r != {(AW+1){1'b0}});
    assign push      = in_valid && in_ready;
    assign pop_s     = out_valid && out_ready;
    assign head_s    = mem_r[rd_ptr_r];
    assign out_sum   = head_s[DATA_W+FLAG_W-1:FLAG_W];
    assign out_flags = head_s[FLAG_W-1:0];

    // Entry storage; contents are don't-care while the slot is unoccupied.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[wr_ptr_r] <= {in_sum, in_flags};
        end
    end

    // Pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/flag_status_unit.sv
// Adder-result buffer with sticky flags, last-flags condition evaluation and
// operation/carry counters around a small result FIFO.
module flag_status_unit
    import flag_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int FLAG_W = 5,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_sum,
    input  logic [FLAG_W-1:0] in_flags,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_sum,
    output logic [FLAG_W-1:0] out_flags,
    input  logic              out_ready,
    input  logic              sticky_clr,
    output logic [FLAG_W-1:0] sticky_flags,
    input  logic [2:0]        cond_sel,
    output logic              cond_true,
    output logic [7:0]        op_count,
    output logic [7:0]        carry_count
);

    logic              push_s;
    logic [FLAG_W-1:0] sticky_r;
    logic [FLAG_W-1:0] last_flags_r;
    logic [7:0]        op_count_r;
    logic [7:0]        carry_count_r;

    flag_fifo #(
        .DATA_W (DATA_W),
        .FLAG_W (FLAG_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_sum    (in_sum),
        .in_flags  (in_flags),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_sum   (out_sum),
        .out_flags (out_flags),
        .out_ready (out_ready),
        .push      (push_s)
    );

    // Sticky accumulation; a clear coinciding with a push keeps only the new flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_r <= {FLAG_W{1'b0}};
        end else if (sticky_clr && push_s) begin
            sticky_r <= in_flags;
        end else if (sticky_clr) begin
            sticky_r <= {FLAG_W{1'b0}};
        end else if (push_s) begin
            sticky_r <= sticky_r | in_flags;
        end
    end

    // Last accepted flags and counters; carry count saturates, op count wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_flags_r  <= {FLAG_W{1'b0}};
            op_count_r    <= 8'd0;
            carry_count_r <= 8'd0;
        end else if (push_s) begin
            last_flags_r <= in_flags;
            op_count_r   <= op_count_r + 8'd1;
            if (in_flags[FLAG_CARRY] && (carry_count_r != 8'hFF)) begin
                carry_count_r <= carry_count_r + 8'd1;
            end
        end
    end

    // Condition select evaluated on the most recently accepted flags.
    always_comb begin
        cond_true = eval_cond(cond_sel, last_flags_r[FLAG_COUNT-1:0]);
    end

    assign sticky_flags = sticky_r;
    assign op_count     = op_count_r;
    assign carry_count  = carry_count_r;

endmodule

// File: tb/tb_flag_status_unit.sv
// Scoreboard bench for flag_status_unit: directed pushes queue expected
// {sum, flags}; a negedge monitor checks every popped head in order.
module tb_flag_status_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_sum = 8'h00;
    logic [4:0] in_flags = 5'b00000;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_sum;
    logic [4:0] out_flags;
    logic       out_ready = 1'b0;
    logic       sticky_clr = 1'b0;
    logic [4:0] sticky_flags;
    logic [2:0] cond_sel = 3'd0;
    logic       cond_true;
    logic [7:0] op_count;
    logic [7:0] carry_count;

    int errors = 0;
    int checks = 0;
    logic [12:0] exp_q [$];

    flag_status_unit #(.DATA_W(8), .FLAG_W(5), .DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_sum       (in_sum),
        .in_flags     (in_flags),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_sum      (out_sum),
        .out_flags    (out_flags),
        .out_ready    (out_ready),
        .sticky_clr   (sticky_clr),
        .sticky_flags (sticky_flags),
        .cond_sel     (cond_sel),
        .cond_true    (cond_true),
        .op_count     (op_count),
        .carry_count  (carry_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one result for one cycle; acc is the hand-stated acceptance.
    task automatic offer(input logic [7:0] s, input logic [4:0] f, input logic acc);
        in_valid = 1'b1;
        in_sum   = s;
        in_flags = f;
        chk("in_ready_on_offer", {31'd0, in_ready}, {31'd0, acc});
        if (acc) exp_q.push_back({s, f});
        step();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
    endtask

    // Monitor: every head taken by the consumer must match the queue front.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop: got sum 0x%0h flags 0x%0h expected none", out_sum, out_flags);
            end else begin
                chk("pop_sum", {24'd0, out_sum}, {24'd0, exp_q[0][12:5]});
                chk("pop_flags", {27'd0, out_flags}, {27'd0, exp_q[0][4:0]});
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        // Reset state
        step();
        do_reset();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sticky", {27'd0, sticky_flags}, 32'd0);
        chk("rst_op_count", {24'd0, op_count}, 32'd0);
        chk("rst_carry_count", {24'd0, carry_count}, 32'd0);
        for (int s = 0; s < 8; s++) begin
            cond_sel = 3'(s);
            #1;
            chk("rst_cond", {31'd0, cond_true}, (s >= 5) ? 32'd1 : 32'd0);
        end
        step();

        // Fill to full, refused fifth offer, then drain in order
        out_ready = 1'b0;
        offer(8'h11, 5'b00000, 1'b1);
        offer(8'h22, 5'b00010, 1'b1);
        offer(8'h33, 5'b01000, 1'b1);
        offer(8'h44, 5'b00100, 1'b1);
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        chk("full_out_valid", {31'd0, out_valid}, 32'd1);
        offer(8'h55, 5'b10001, 1'b0);
        chk("full_op_count", {24'd0, op_count}, 32'd4);
        chk("full_sticky", {27'd0, sticky_flags}, 32'b01110);
        chk("full_carry", {24'd0, carry_count}, 32'd0);
        out_ready = 1'b1;
        repeat (4) step();
        chk("drained_out_valid", {31'd0, out_valid}, 32'd0);
        chk("drained_queue", exp_q.size(), 32'd0);

        // Sticky, counters and carry condition
        do_reset();
        offer(8'h00, 5'b01001, 1'b1);
        offer(8'h10, 5'b10100, 1'b1);
        chk("sticky_or", {27'd0, sticky_flags}, 32'b11101);
        chk("carry_one", {24'd0, carry_count}, 32'd1);
        chk("op_two", {24'd0, op_count}, 32'd2);
        cond_sel = 3'd4; #1;
        chk("cond_carry", {31'd0, cond_true}, 32'd1);
        cond_sel = 3'd0; #1;
        chk("cond_zero", {31'd0, cond_true}, 32'd0);
        cond_sel = 3'd6; #1;
        chk("cond_ncarry", {31'd0, cond_true}, 32'd0);
        step();

        // Clear together with a push keeps only the new flags; clear alone zeroes
        sticky_clr = 1'b1;
        offer(8'h77, 5'b00010, 1'b1);
        chk("clr_push_sticky", {27'd0, sticky_flags}, 32'b00010);
        chk("clr_push_op", {24'd0, op_count}, 32'd3);
        step();
        sticky_clr = 1'b0;
        chk("clr_only_sticky", {27'd0, sticky_flags}, 32'd0);
        cond_sel = 3'd1; #1;
        chk("cond_odd", {31'd0, cond_true}, 32'd1);
        step();
        repeat (2) step();

        // Concurrent push and pop at occupancy 2
        out_ready = 1'b0;
        offer(8'hA0, 5'b00001, 1'b1);
        offer(8'hA1, 5'b00010, 1'b1);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("stream_out_valid", {31'd0, out_valid}, 32'd1);
            offer(8'hB0 + 8'(i), 5'(i), 1'b1);
        end
        chk("tail_valid_1", {31'd0, out_valid}, 32'd1);
        step();
        chk("tail_valid_2", {31'd0, out_valid}, 32'd1);
        step();
        chk("tail_empty", {31'd0, out_valid}, 32'd0);
        chk("stream_queue", exp_q.size(), 32'd0);

        // op_count wrap and carry_count saturation
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            offer(8'(i), 5'b10000, 1'b1);
        end
        chk("wrap_op_zero", {24'd0, op_count}, 32'd0);
        chk("sat_carry_256", {24'd0, carry_count}, 32'd255);
        offer(8'hEE, 5'b10000, 1'b1);
        chk("wrap_op_one", {24'd0, op_count}, 32'd1);
        chk("sat_carry", {24'd0, carry_count}, 32'd255);
        step();

        // Reset mid-stream with entries held and a push/pop/clear pending
        out_ready = 1'b0;
        offer(8'hC0, 5'b10001, 1'b1);
        offer(8'hC1, 5'b01000, 1'b1);
        offer(8'hC2, 5'b00100, 1'b1);
        in_valid   = 1'b1;
        in_sum     = 8'hC3;
        in_flags   = 5'b10000;
        out_ready  = 1'b1;
        sticky_clr = 1'b1;
        do_reset();
        in_valid   = 1'b0;
        sticky_clr = 1'b0;
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_rst_sticky", {27'd0, sticky_flags}, 32'd0);
        chk("mid_rst_op", {24'd0, op_count}, 32'd0);
        chk("mid_rst_carry", {24'd0, carry_count}, 32'd0);
        cond_sel = 3'd4; #1;
        chk("mid_rst_cond", {31'd0, cond_true}, 32'd0);
        step();
        chk("mid_rst_still_empty", {31'd0, out_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/flag_status_unit.md
FLAG_STATUS_UNIT -- requirements
Module: flag_status_unit

Interface
REQ-001 The block SHALL take parameter DATA_W, default 8, as the result width (Sum).
REQ-002 The block SHALL take parameter FLAG_W, default 5, as the flag width (Flags[4:0]).
REQ-003 The block SHALL take parameter DEPTH, default 4, as the result FIFO depth (power of 2, >=2).
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 The block SHALL have port in_valid, input, 1, meaning an adder result is offered.
REQ-007 The block SHALL have port in_sum, input, DATA_W, the adder Sum.
REQ-008 The block SHALL have port in_flags, input, FLAG_W, the adder flags: [0] zero, [1] odd parity, [2] aux carry, [3] even, [4] carry.
REQ-009 The block SHALL have port in_ready, output, 1, meaning the FIFO can accept.
REQ-010 The block SHALL have port out_valid, output, 1, meaning the FIFO head is valid.
REQ-011 The block SHALL have port out_sum, output, DATA_W, the head Sum.
REQ-012 The block SHALL have port out_flags, output, FLAG_W, the head flags.
REQ-013 The block SHALL have port out_ready, input, 1, meaning the consumer takes the head.
REQ-014 The block SHALL have port sticky_clr, input, 1, which clears the sticky flags.
REQ-015 The block SHALL have port sticky_flags, output, FLAG_W, the OR of all accepted flags since the last clear.
REQ-016 The block SHALL have port cond_sel, input, 3, the condition select.
REQ-017 The block SHALL have port cond_true, output, 1, the selected condition evaluated on last_flags.
REQ-018 The block SHALL have port op_count, output, 8, the accepted-result count.
REQ-019 The block SHALL have port carry_count, output, 8, the count of accepted results with carry set.

Function
REQ-020 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-021 in_ready SHALL equal (occupancy < DEPTH); there is no pass-through when full.
REQ-022 out_valid SHALL equal (occupancy > 0); out_sum and out_flags SHALL show the head entry combinationally from storage.
REQ-023 Latency SHALL be 1 cycle: data pushed at edge N SHALL be visible at the outputs after edge N.
REQ-024 A simultaneous push and pop SHALL leave occupancy unchanged and preserve FIFO order.
REQ-025 Pointers SHALL wrap modulo DEPTH; occupancy SHALL have range 0..DEPTH.
REQ-026 On push, last_flags SHALL take in_flags; last_flags SHALL otherwise hold.
REQ-027 Sticky update SHALL be: with sticky_clr and push, sticky = in_flags; with sticky_clr only, sticky = 0; with push only, sticky |= in_flags.
REQ-028 op_count SHALL increment by 1 per push and wrap from 255 to 0.
REQ-029 carry_count SHALL increment on a push with in_flags[4]=1 and saturate at 255.
REQ-030 cond_true SHALL be combinational: sel 0 zero, 1 odd parity, 2 aux, 3 even, 4 carry, 5 !zero, 6 !carry, 7 constant 1.
REQ-031 An offered result while full SHALL NOT alter any state; the producer holds in_valid.

Reset
REQ-032 On rst: occupancy=0, pointers=0, in_ready=1, out_valid=0, sticky_flags=0, last_flags=0, op_count=0, carry_count=0.
REQ-033 rst SHALL dominate push, pop and sticky_clr in the same cycle.
REQ-034 rst mid-stream SHALL discard all FIFO entries.
REQ-035 After rst, cond_true SHALL be 1 for sel 5, 6 and 7, and 0 otherwise.

Structure
REQ-036 Package flag_pkg SHALL hold the flag bit indices (FLAG_ZERO=0 .. FLAG_CARRY=4) and the cond_sel encodings.
REQ-037 One sub-module, flag_fifo, SHALL hold {sum,flags} storage, pointers and occupancy.
REQ-038 The top level SHALL contain only the sticky, last_flags, counter and condition logic.

Verification
REQ-039 Bench SHALL push 4 results with out_ready=0: in_ready=0 after the 4th; a 5th offer with sum 0x55 SHALL be ignored; draining SHALL return the 4 results in order.
REQ-040 Bench SHALL push sum 0x00 with flags 0b01001, then sum 0x10 with flags 0b10100: sticky=0b11101, carry_count=1, op_count=2, cond_sel=4 gives cond_true=1.
REQ-041 Bench SHALL assert sticky_clr and a push of flags 0b00010 in the same cycle: sticky=0b00010.
REQ-042 Bench SHALL run push and pop together at occupancy 2 for 10 cycles: occupancy stays 2 and order is preserved.
REQ-043 Bench SHALL push 256 carry results and then 1 more: op_count=1 (wrapped), carry_count=255 (saturated).
REQ-044 Bench SHALL assert rst with 3 entries held and in_valid=1: next cycle out_valid=0, occupancy=0, all counters and sticky cleared.
